bist: RTL and testbench
=======================

BIST -- requirements
Module: bist

Interface
REQ-001 SHALL have parameter SIZE, default 6, memory address width (memory depth 2^SIZE words).
REQ-002 SHALL have parameter LENGTH, default 8, memory word width; SHALL be a multiple of 4.
REQ-003 SHALL use one clock and a reset that is synchronous and active-high (clk, rst); all state changes occur on rising clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  level request to begin a self-test run.
REQ-007 csin  input  1  normal-mode chip select.
REQ-008 rwbarin  input  1  normal-mode read (1) / write (0).
REQ-009 opr  input  1  fail-detection enable; 0 = comparator results ignored.
REQ-010 address  input  SIZE  normal-mode memory address.
REQ-011 datain  input  LENGTH  normal-mode write data.
REQ-012 dataout  output  LENGTH  memory read data.
REQ-013 fail  output  1  sticky self-test mismatch flag.

Function
REQ-014 SHALL contain a single-port RAM of 2^SIZE x LENGTH; write on rising clk when cs=1 and rwbar=0; read combinational.
REQ-015 dataout SHALL equal mem[addr] when cs=1 and rwbar=1, else all zeros (including during writes).
REQ-016 SHALL contain a two-state controller: IDLE (normal mode) and TEST.
REQ-017 IDLE -> TEST on the rising edge where start=1; TEST -> IDLE on the edge where the test counter is all ones; start is ignored in TEST.
REQ-018 In IDLE, the memory cs, rwbar, addr and write data SHALL come directly from csin, rwbarin, address and datain.
REQ-019 In TEST, cs SHALL be forced to 1, and addr, rwbar and write data SHALL come from the test counter and pattern generator; normal inputs are ignored.
REQ-020 The test counter SHALL be SIZE+4 bits, held at 0 in IDLE, and increment by 1 each clock in TEST.
REQ-021 Counter bits [SIZE-1:0] SHALL drive addr, bit [SIZE] SHALL drive rwbar (0 = write pass, 1 = read pass), and bits [SIZE+3:SIZE+1] SHALL select the pattern.
REQ-022 Patterns 0..7 (shown at LENGTH=8, replicated for wider words) SHALL be: 10101010, 01010101, 11110000, 00001111, 00000000, 11111111, 11001100, 00110011.
REQ-023 Each pattern therefore runs a full write pass over all addresses, then a full read pass; the first TEST cycle writes pattern 0 to address 0.
REQ-024 On a TEST read-pass edge with opr=1 and dataout != current pattern, fail SHALL be set to 1.
REQ-025 fail SHALL remain set until rst, or until the IDLE -> TEST transition, which clears it.
REQ-026 fail SHALL remain set after the test completes, so the result is readable in IDLE.
REQ-027 A complete run SHALL last 2^(SIZE+4) clocks in TEST; at that edge the controller returns to IDLE and the counter returns to 0.
REQ-028 The implementation SHALL be 120-400 lines of RTL, partitioned into controller, counter, pattern decoder, input muxes, RAM and comparator.

Reset
REQ-029 On a rising edge with rst=1: controller -> IDLE, counter -> 0, fail -> 0; this takes priority over start and over terminal count.
REQ-030 rst SHALL NOT clear RAM contents; an rst asserted mid-test aborts the run and leaves any words already written by the test in place.
REQ-031 After reset with csin=0, dataout=0 and fail=0.

Verification
REQ-032 Reset, then csin=1, rwbarin=0, address=0, datain=10 for one clock; then rwbarin=1 -> dataout=10 combinationally, fail=0.
REQ-033 From IDLE, start=1 for one edge -> TEST; immediately after that edge dataout=0 (write pass), fail=0.
REQ-034 Run TEST for 4 clocks, assert rst for one edge, then csin=1, rwbarin=1, address=0 -> dataout=10101010 and fail=0; addresses 1-3 also read 10101010.
REQ-035 Full run with opr=1 on a fault-free memory -> fail=0 throughout; controller back in IDLE after 1024 TEST clocks (SIZE=6).
REQ-036 Full run with one RAM bit forced stuck -> fail=1 after the first read of the corrupted word, held in IDLE, cleared by rst; with opr=0, fail stays 0.
REQ-037 Toggle csin and rwbarin during TEST -> no effect on the counter sequence or on the RAM contents written.

Source files
------------

// File: rtl/bist_if.sv
// rtl/bist_if.sv - BIST memory port and control bundle
//
// Ports carried:
//   start   - level request to begin a self-test run
//   csin    - normal-mode chip select
//   rwbarin - normal-mode read (1) / write (0)
//   opr     - fail-detection enable
//   address - normal-mode memory address (SIZE bits)
//   datain  - normal-mode write data (LENGTH bits)
//   dataout - memory read data, zero unless reading
//   fail    - sticky self-test mismatch flag
// master drives the requests, slave is the bist block.
interface bist_if #(
   parameter int SIZE   = 6,
   parameter int LENGTH = 8
);
   logic              start;
   logic              csin;
   logic              rwbarin;
   logic              opr;
   logic [SIZE-1:0]   address;
   logic [LENGTH-1:0] datain;
   logic [LENGTH-1:0] dataout;
   logic              fail;

   modport master (
      output start, csin, rwbarin, opr, address, datain,
      input  dataout, fail
   );

   modport slave (
      input  start, csin, rwbarin, opr, address, datain,
      output dataout, fail
   );
endinterface

// File: rtl/bist.sv
// rtl/bist.sv - memory with built-in march-style pattern self-test
//
// Ports:
//   clk - system clock, all state changes on rising edge
//   rst - synchronous active-high reset (controller, counter, fail; RAM kept)
//   bus - bist_if.slave: start/csin/rwbarin/opr/address/datain in,
//         dataout/fail out
// Blocks: controller (IDLE/TEST), test counter, pattern decoder,
// input muxes, single-port RAM with combinational read, comparator.
module bist #(
   parameter int SIZE   = 6,
   parameter int LENGTH = 8
) (
   input logic   clk,
   input logic   rst,
   bist_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, TEST = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [SIZE+3:0]   cnt_q, cnt_d;
   logic              fail_q, fail_d;
   logic              term;

   logic [2:0]        pat_sel;
   logic [7:0]        pat_byte;
   logic [LENGTH-1:0] pattern;

   logic              mem_cs;
   logic              mem_rwbar;
   logic [SIZE-1:0]   mem_addr;
   logic [LENGTH-1:0] mem_wdata;
   logic [LENGTH-1:0] rd_word;
   logic [LENGTH-1:0] mem [2**SIZE];

   // Counter layout: [SIZE-1:0] address, [SIZE] read pass, top 3 bits pattern.
   assign term    = &cnt_q;
   assign pat_sel = cnt_q[SIZE+3:SIZE+1];

   always_comb begin
      pat_byte = 8'hAA;
      case (pat_sel)
         3'd0: pat_byte = 8'hAA;
         3'd1: pat_byte = 8'h55;
         3'd2: pat_byte = 8'hF0;
         3'd3: pat_byte = 8'h0F;
         3'd4: pat_byte = 8'h00;
         3'd5: pat_byte = 8'hFF;
         3'd6: pat_byte = 8'hCC;
         3'd7: pat_byte = 8'h33;
         default: pat_byte = 8'hAA;
      endcase
   end

   // Byte pattern tiled across the word; a 4-bit-multiple width may cut
   // the last byte in half.
   always_comb begin
      pattern = '0;
      for (int i = 0; i < LENGTH; i++) begin
         pattern[i] = pat_byte[3'(i)];
      end
   end

   // In TEST the normal-mode inputs are completely ignored.
   always_comb begin
      if (state_q == TEST) begin
         mem_cs    = 1'b1;
         mem_rwbar = cnt_q[SIZE];
         mem_addr  = cnt_q[SIZE-1:0];
         mem_wdata = pattern;
      end else begin
         mem_cs    = bus.csin;
         mem_rwbar = bus.rwbarin;
         mem_addr  = bus.address;
         mem_wdata = bus.datain;
      end
   end

   // RAM is deliberately outside reset so an aborted run keeps its writes.
   always_ff @(posedge clk) begin
      if (mem_cs && !mem_rwbar) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   assign rd_word     = mem[mem_addr];
   assign bus.dataout = (mem_cs && mem_rwbar) ? rd_word : '0;
   assign bus.fail    = fail_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.start) begin
               state_d = TEST;
               fail_d  = 1'b0;
            end
         end
         TEST: begin
            // Terminal count wraps the counter back to zero on its own.
            cnt_d = cnt_q + 1'b1;
            if (mem_rwbar && bus.opr && (bus.dataout != pattern)) begin
               fail_d = 1'b1;
            end
            if (term) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fail_q  <= fail_d;
      end
   end

endmodule

// File: tb/tb_bist.sv
// tb/tb_bist.sv - randomized self-checking bench for bist
module tb_bist;
   localparam int SIZE   = 6;
   localparam int LENGTH = 8;
   localparam int DEPTH  = 64;
   localparam int RUN    = 1024;
   localparam int FA     = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bist_if #(.SIZE(SIZE), .LENGTH(LENGTH)) bus ();
   bist #(.SIZE(SIZE), .LENGTH(LENGTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: run position k counts TEST clocks since start.
   bit          m_test;
   int          m_k;
   bit          m_fail;
   logic [7:0]  m_mem [DEPTH];
   logic [7:0]  pat_tab [8];
   bit          fault_on;
   logic [7:0]  fval;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // A cell with bit 0 stuck at 1 at address FA.
   function automatic logic [7:0] m_read(input int a);
      if (fault_on && a == FA) return m_mem[a] | 8'h01;
      return m_mem[a];
   endfunction

   task automatic cycle();
      int         a;
      bit         rd, wr;
      logic [7:0] pat, wdat, exp_do;
      bit         n_test, n_fail;
      int         n_k;
      pat = pat_tab[(m_k >> 7) & 7];
      if (m_test) begin
         a  = m_k % DEPTH;
         rd = ((m_k >> 6) & 1) == 1;
         wr = !rd;
         wdat = pat;
      end else begin
         a  = int'(bus.address);
         rd = bus.csin && bus.rwbarin;
         wr = bus.csin && !bus.rwbarin;
         wdat = bus.datain;
      end
      if (fault_on && a == FA) begin
         fval = m_mem[FA] | 8'h01;
         force dut.rd_word = fval;
      end else begin
         release dut.rd_word;
      end
      #1;
      exp_do = rd ? m_read(a) : 8'h00;
      check("dataout", 32'(bus.dataout), 32'(exp_do));
      check("fail", 32'(bus.fail), 32'(m_fail));
      n_test = m_test;
      n_k    = m_k;
      n_fail = m_fail;
      if (rst) begin
         n_test = 0; n_k = 0; n_fail = 0;
      end else if (!m_test) begin
         if (bus.start) begin
            n_test = 1; n_fail = 0;
         end
      end else begin
         if (rd && bus.opr && m_read(a) != pat) n_fail = 1;
         if (m_k == RUN - 1) begin
            n_test = 0; n_k = 0;
         end else begin
            n_k = m_k + 1;
         end
      end
      @(posedge clk);
      if (wr) m_mem[a] = wdat;
      m_test = n_test;
      m_k    = n_k;
      m_fail = n_fail;
      #1;
   endtask

   task automatic rand_inputs(input int start_pct);
      bus.csin    = 1'($urandom);
      bus.rwbarin = 1'($urandom);
      bus.address = SIZE'($urandom);
      bus.datain  = LENGTH'($urandom);
      bus.start   = ($urandom_range(0, 99) < start_pct);
   endtask

   task automatic full_run(input bit opr_v);
      bus.opr   = opr_v;
      bus.csin  = 1'b0;
      bus.start = 1'b1;
      cycle();
      for (int i = 0; i < RUN; i++) begin
         rand_inputs(30);
         cycle();
      end
      bus.start = 1'b0;
   endtask

   initial begin
      pat_tab = '{8'hAA, 8'h55, 8'hF0, 8'h0F, 8'h00, 8'hFF, 8'hCC, 8'h33};
      fault_on = 0;
      m_test = 0; m_k = 0; m_fail = 0;
      rst = 1'b1;
      bus.start = 0; bus.csin = 0; bus.rwbarin = 0; bus.opr = 1;
      bus.address = '0; bus.datain = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_dataout", 32'(bus.dataout), 32'h0);
      check("rst_fail", 32'(bus.fail), 32'h0);

      // Simple write then combinational read.
      bus.csin = 1; bus.rwbarin = 0; bus.address = 0; bus.datain = 8'd10;
      cycle();
      bus.rwbarin = 1;
      #1;
      check("rd_after_wr", 32'(bus.dataout), 32'd10);
      cycle();
      for (int a = 1; a < DEPTH; a++) begin
         bus.rwbarin = 0; bus.address = SIZE'(a); bus.datain = LENGTH'($urandom);
         cycle();
      end

      // Start, first TEST cycle is a write.
      bus.csin = 1; bus.rwbarin = 1; bus.start = 1;
      cycle();
      bus.start = 0;
      check("test_wr_dataout", 32'(bus.dataout), 32'h0);
      check("test_fail", 32'(bus.fail), 32'h0);
      repeat (3) cycle();
      rst = 1;
      cycle();
      rst = 0;
      bus.csin = 1; bus.rwbarin = 1;
      for (int a = 0; a < 4; a++) begin
         bus.address = SIZE'(a);
         #1;
         check("abort_keep", 32'(bus.dataout), 32'hAA);
      end
      check("abort_fail", 32'(bus.fail), 32'h0);
      cycle();

      // Fault-free run with input toggling during TEST.
      full_run(1'b1);
      bus.csin = 1; bus.rwbarin = 1; bus.address = 7;
      #1;
      check("post_run_read", 32'(bus.dataout), 32'h33);
      check("post_run_fail", 32'(bus.fail), 32'h0);
      cycle();

      // Stuck bit, detection enabled.
      fault_on = 1;
      full_run(1'b1);
      check("fault_fail", 32'(bus.fail), 32'h1);
      repeat (5) begin
         rand_inputs(0);
         cycle();
      end
      check("fault_held", 32'(bus.fail), 32'h1);
      rst = 1;
      cycle();
      rst = 0;
      check("fault_rst_clr", 32'(bus.fail), 32'h0);

      // Stuck bit, detection disabled.
      full_run(1'b0);
      check("opr0_fail", 32'(bus.fail), 32'h0);
      fault_on = 0;
      release dut.rd_word;
      cycle();

      // Mixed random traffic with occasional resets and starts.
      for (int i = 0; i < 3000; i++) begin
         rand_inputs(2);
         bus.opr = 1'($urandom);
         rst = ($urandom_range(0, 499) == 0);
         cycle();
      end
      rst = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
